axi_rd_responder: RTL

//   AXI4 read-only responder (AR/R slave) fronting a single-port synchronous SRAM with 1-cycle read latency.
//   It is the memory-side counterpart of the ifu/icache AXI read master, and serves as the boot/instruction memory in SoC and testbench builds.
//   One outstanding transaction at a time. Supports FIXED, INCR and WRAP bursts with R-channel backpressure.

---
 rtl/axi_rd_responder_pkg.sv | 28 ++
 rtl/axi_rd_responder_skid.sv | 81 ++++++++
 rtl/axi_rd_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_responder_pkg.sv
// Shared AXI encodings and FSM state type for the AXI read responder.
package axi_rd_responder_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    function automatic logic wrap_len_legal(input logic [7:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction

endpackage

// File: rtl/axi_rd_responder_skid.sv
// Two-entry R-beat FIFO {data,resp,last}; an empty FIFO passes the incoming
// beat straight through so the SRAM read latency is not extended.
module axi_rd_responder_skid #(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic [1:0]    push_resp_i,
    input  logic          push_last_i,
    input  logic          pop_ready_i,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    out_resp_o,
    output logic          out_last_o,
    output logic [1:0]    count_o
);

    localparam int unsigned EW = DW + 3;

    logic [EW-1:0] ent_q [2];
    logic [EW-1:0] ent_d [2];
    logic [1:0]    cnt_q;
    logic [1:0]    cnt_d;
    logic [EW-1:0] in_ent;
    logic [EW-1:0] head;
    logic          pop;

    assign in_ent      = {push_data_i, push_resp_i, push_last_i};
    assign head        = (cnt_q != 2'd0) ? ent_q[0] : in_ent;
    assign out_valid_o = (cnt_q != 2'd0) | push_i;
    assign pop         = out_valid_o & pop_ready_i;
    assign out_data_o  = head[EW-1:3];
    assign out_resp_o  = head[2:1];
    assign out_last_o  = out_valid_o & head[0];
    assign count_o     = cnt_q;

    // Upstream never pushes into a full FIFO without a pop (issue is gated on count).
    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push_i && !pop_ready_i) begin
                    ent_d[0] = in_ent;
                    cnt_d    = 2'd1;
                end
            end
            2'd1: begin
                if (pop) begin
                    if (push_i) ent_d[0] = in_ent;
                    else        cnt_d    = 2'd0;
                end else if (push_i) begin
                    ent_d[1] = in_ent;
                    cnt_d    = 2'd2;
                end
            end
            2'd2: begin
                if (pop) begin
                    ent_d[0] = ent_q[1];
                    if (push_i) ent_d[1] = in_ent;
                    else        cnt_d    = 2'd1;
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            cnt_q    <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-only responder (AR/R) in front of a 1-cycle-latency SRAM;
// one transaction at a time, FIXED/INCR/WRAP bursts, SLVERR for illegal beats.
module axi_rd_responder
    import axi_rd_responder_pkg::*;
#(
    parameter int unsigned                AXI_P_DW_BYTES = 3,
    parameter int unsigned                AXI_ADDR_WIDTH = 64,
    parameter int unsigned                AXI_ID_WIDTH   = 4,
    parameter int unsigned                AXI_USER_WIDTH = 1,
    parameter int unsigned                MEM_P_DEPTH    = 14,
    parameter logic [AXI_ADDR_WIDTH-1:0]  MEM_BASE       = 'h8000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          axi_ar_valid_i,
    output logic                          axi_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_ar_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]       axi_ar_id_i,
    input  logic [AXI_USER_WIDTH-1:0]     axi_ar_user_i,
    input  logic [7:0]                    axi_ar_len_i,
    input  logic [2:0]                    axi_ar_size_i,
    input  logic [1:0]                    axi_ar_burst_i,
    input  logic [2:0]                    axi_ar_prot_i,
    input  logic                          axi_ar_lock_i,
    input  logic [3:0]                    axi_ar_cache_i,
    input  logic [3:0]                    axi_ar_qos_i,
    input  logic [3:0]                    axi_ar_region_i,
    input  logic                          axi_r_ready_i,
    output logic                          axi_r_valid_o,
    output logic [(8<<AXI_P_DW_BYTES)-1:0] axi_r_data_o,
    output logic [1:0]                    axi_r_resp_o,
    output logic                          axi_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]       axi_r_id_o,
    output logic [AXI_USER_WIDTH-1:0]     axi_r_user_o,
    output logic                          mem_re_o,
    output logic [MEM_P_DEPTH-1:0]        mem_addr_o,
    input  logic [(8<<AXI_P_DW_BYTES)-1:0] mem_rdata_i
);

    localparam int unsigned DW       = 8 << AXI_P_DW_BYTES;
    localparam int unsigned AW       = AXI_ADDR_WIDTH;
    localparam int unsigned WIN_LOG2 = MEM_P_DEPTH + AXI_P_DW_BYTES;

    rd_state_e               state_q, state_d;
    logic                    ar_ready_q, ar_ready_d;
    logic [AXI_ID_WIDTH-1:0] id_q, id_d;
    logic [AXI_USER_WIDTH-1:0] user_q, user_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    axi_burst_e              burst_q, burst_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic                    burst_err_q, burst_err_d;
    logic                    infl_q, infl_d;
    logic                    infl_err_q, infl_err_d;
    logic                    infl_last_q, infl_last_d;

    logic [AW-1:0]           step, wrap_mask, addr_inc, addr_next, off;
    logic                    in_range, beat_err, beat_last, issue;
    logic [1:0]              skid_cnt;
    logic                    unused_ok;

    assign unused_ok = ^{axi_ar_prot_i, axi_ar_lock_i, axi_ar_cache_i,
                         axi_ar_qos_i, axi_ar_region_i};

    assign step      = AW'(1) << size_q;
    assign wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    assign addr_inc  = addr_q + step;

    always_comb begin
        case (burst_q)
            BURST_FIXED: addr_next = addr_q;
            BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
            default:     addr_next = addr_inc;
        endcase
    end

    // Addresses below MEM_BASE wrap to a huge offset, so one compare covers both bounds.
    assign off        = addr_q - MEM_BASE;
    assign in_range   = (off >> WIN_LOG2) == '0;
    assign beat_err   = burst_err_q | ~in_range;
    assign beat_last  = (beat_cnt_q == len_q);
    assign mem_addr_o = off[WIN_LOG2-1:AXI_P_DW_BYTES];
    assign mem_re_o   = issue & ~beat_err;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        user_d      = user_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        addr_d      = addr_q;
        beat_cnt_d  = beat_cnt_q;
        burst_err_d = burst_err_q;
        issue       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (axi_ar_valid_i && ar_ready_q) begin
                    id_d        = axi_ar_id_i;
                    user_d      = axi_ar_user_i;
                    len_d       = axi_ar_len_i;
                    size_d      = axi_ar_size_i;
                    burst_d     = axi_burst_e'(axi_ar_burst_i);
                    addr_d      = axi_ar_addr_i;
                    beat_cnt_d  = '0;
                    burst_err_d = (axi_ar_size_i > 3'(AXI_P_DW_BYTES))
                                | (axi_ar_burst_i == BURST_RSVD)
                                | ((axi_ar_burst_i == BURST_WRAP) && !wrap_len_legal(axi_ar_len_i));
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                if ((2'(infl_q) + skid_cnt) < 2'd2) begin
                    issue      = 1'b1;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    addr_d     = addr_next;
                    if (beat_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((skid_cnt == 2'd0 && !infl_q) ||
                    (axi_r_valid_o && axi_r_ready_i && axi_r_last_o)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ar_ready_d  = (state_d == ST_IDLE);
        infl_d      = issue;
        infl_err_d  = issue & beat_err;
        infl_last_d = issue & beat_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ar_ready_q  <= 1'b0;
            id_q        <= '0;
            user_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= BURST_FIXED;
            addr_q      <= '0;
            beat_cnt_q  <= '0;
            burst_err_q <= 1'b0;
            infl_q      <= 1'b0;
            infl_err_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ar_ready_q  <= ar_ready_d;
            id_q        <= id_d;
            user_q      <= user_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            addr_q      <= addr_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_err_q <= burst_err_d;
            infl_q      <= infl_d;
            infl_err_q  <= infl_err_d;
            infl_last_q <= infl_last_d;
        end
    end

    assign axi_ar_ready_o = ar_ready_q;
    assign axi_r_id_o     = id_q;
    assign axi_r_user_o   = user_q;

    axi_rd_responder_skid #(
        .DW (DW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (infl_q),
        .push_data_i (infl_err_q ? '0 : mem_rdata_i),
        .push_resp_i (infl_err_q ? RESP_SLVERR : RESP_OKAY),
        .push_last_i (infl_last_q),
        .pop_ready_i (axi_r_ready_i),
        .out_valid_o (axi_r_valid_o),
        .out_data_o  (axi_r_data_o),
        .out_resp_o  (axi_r_resp_o),
        .out_last_o  (axi_r_last_o),
        .count_o     (skid_cnt)
    );

endmodule
